// File: rtl/alu_pkg.sv
// Shared types and constants for the round-robin ALU scheduler and its ALU.
package alu_pkg;
  localparam int WIDTH = 4;
  localparam int NREQ  = 2;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ADD   = 2'd1,
    SUB   = 2'd2,
    NO_OP = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;
endpackage

// File: rtl/alu_rr_sched_if.sv
// Two requester channels plus the response channel of the shared-ALU scheduler.
interface alu_rr_sched_if #(
  parameter int WIDTH = alu_pkg::WIDTH
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_flag;
  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_out, rsp_flag, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_out, rsp_flag, busy
  );
endinterface

// File: rtl/my_alu.sv
// Combinational 4-bit ALU: OFF, ADD with carry, SUB as magnitude with a-less-than-b flag.
module my_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             flag
);
  if (WIDTH != 4) begin : g_width_chk
    $error("my_alu: WIDTH must be 4");
  end

  logic [WIDTH:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    out  = '0;
    flag = 1'b0;
    case (op)
      ADD: begin
        out  = sum[WIDTH-1:0];
        flag = sum[WIDTH];
      end
      // SUB reports |a-b| and flags when the operands had to be swapped
      SUB: begin
        if (a < b) begin
          out  = b - a;
          flag = 1'b1;
        end else begin
          out  = a - b;
        end
      end
      default: begin
        out  = '0;
        flag = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU between two requesters; one op in flight,
// IDLE -> EXEC -> RESP, result returned with the owning requester id.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREQ  = alu_pkg::NREQ
) (
  input logic           clk,
  input logic           rst_n,
  alu_rr_sched_if.slave bus
);
  if (WIDTH != 4) begin : g_width_chk
    $error("alu_rr_sched: WIDTH must be 4");
  end
  if (NREQ != 2) begin : g_nreq_chk
    $error("alu_rr_sched: NREQ must be 2");
  end

  sched_state_e     state;
  logic             ptr;
  alu_op_e          op_c;
  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic             id_c;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_out_r;
  logic             rsp_flag_r;
  logic             busy_r;
  logic             gnt0;
  logic             gnt1;
  alu_op_e          alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_flag;

  // Grant only in IDLE; pointer breaks ties. Gated by rst_n so nothing is accepted in reset.
  assign gnt0 = rst_n && (state == IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr);
  assign gnt1 = rst_n && (state == IDLE) && bus.req1_valid && (!bus.req0_valid ||  ptr);

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_out    = rsp_out_r;
  assign bus.rsp_flag   = rsp_flag_r;
  assign bus.busy       = busy_r;

  // ALU sees OFF except while executing, so it never carries a stale operation
  assign alu_op = (state == EXEC) ? op_c : OFF;

  my_alu #(.WIDTH(WIDTH)) u_alu (
    .op   (alu_op),
    .a    (a_c),
    .b    (b_c),
    .out  (alu_out),
    .flag (alu_flag)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_out_r   <= '0;
      rsp_flag_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_c   <= gnt1 ? alu_op_e'(bus.req1_op) : alu_op_e'(bus.req0_op);
            a_c    <= gnt1 ? bus.req1_a : bus.req0_a;
            b_c    <= gnt1 ? bus.req1_b : bus.req0_b;
            id_c   <= gnt1;
            ptr    <= gnt0;
            busy_r <= 1'b1;
            state  <= EXEC;
          end
        end
        // NO_OP leaves the previous result in the response registers
        EXEC: begin
          if (op_c != NO_OP) begin
            rsp_out_r  <= alu_out;
            rsp_flag_r <= alu_flag;
          end
          rsp_id_r    <= id_c;
          rsp_valid_r <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
